// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker playback path.
package tracker_pkg;

    // Default tempo accumulator width and the system clock it is timed against.
    localparam int     ACC_WIDTH    = 48;
    localparam longint CLK_FREQ     = 100_000_000;

    // Accumulator increment per BPM: one full wrap of the accumulator per beat.
    localparam longint TEMPO_K      = (longint'(1) << ACC_WIDTH) / (CLK_FREQ * 60);

    // A phrase is a fixed block of sixteen lines.
    localparam int     PHRASE_LINES = 16;
    localparam int     LINE_WIDTH   = $clog2(PHRASE_LINES);

    // One phrase line as stored in the phrase RAM.
    typedef struct packed {
        logic [7:0] note;
        logic [5:0] volume;
        logic [1:0] instrument;
    } phrase_entry_t;

    // Playhead control states.
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PLAY,
        PAUSE,
        DONE
    } seq_state_t;

    // True when the playhead sits on the final line of the phrase.
    function automatic logic is_last_line(input logic [LINE_WIDTH-1:0] line);
        return line == LINE_WIDTH'(PHRASE_LINES - 1);
    endfunction

endpackage

// File: rtl/phrase_sequencer_tempo_nco.sv
// Tempo oscillator: a phase accumulator stepped by tempo * TEMPO_K each
// running cycle. A carry out of the top bit marks the end of a line; the
// wrapped remainder is kept so long-run timing does not drift.
module tempo_nco #(
    parameter int     ACC_WIDTH = 48,
    parameter longint TEMPO_K   = 46912
) (
    input  logic       clk,
    input  logic       reset_active_low,
    input  logic [8:0] tempo,
    input  logic       freeze,
    input  logic       clear,
    output logic       carry
);

    localparam logic [ACC_WIDTH-1:0] K_W = ACC_WIDTH'(TEMPO_K);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   sum;

    // Multiply only; tempo of zero gives a zero step and so no carries.
    assign inc   = ACC_WIDTH'(tempo) * K_W;
    assign sum   = {1'b0, acc} + {1'b0, inc};

    // A carry only counts on a cycle where the accumulator actually steps.
    assign carry = !freeze && !clear && sum[ACC_WIDTH];

    // Phase accumulator: cleared by stop, held while frozen, else stepped.
    always_ff @(posedge clk or negedge reset_active_low) begin
        if (!reset_active_low) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (!freeze) begin
            acc <= sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/phrase_sequencer.sv
// Phrase playhead: walks the sixteen lines of a phrase at the tempo rate,
// fetches each line from the synchronous phrase RAM and holds it on
// current_entry for the synth stage. Handles loop, stop and pause.
module phrase_sequencer #(
    parameter int     ACC_WIDTH = tracker_pkg::ACC_WIDTH,
    parameter longint CLK_FREQ  = tracker_pkg::CLK_FREQ,
    parameter longint TEMPO_K   = (longint'(1) << ACC_WIDTH) / (CLK_FREQ * 60)
) (
    input  logic        clk,
    input  logic        reset_active_low,
    input  logic [8:0]  tempo,
    input  logic        play_enable,
    input  logic        loop_enable,
    input  logic        stop,
    output logic        mem_rd_en,
    output logic [3:0]  mem_addr,
    input  logic [15:0] mem_rd_data,
    output logic [15:0] current_entry,
    output logic        entry_valid,
    output logic [3:0]  line_count,
    output logic        line_tick,
    output logic        phrase_done
);

    import tracker_pkg::*;

    seq_state_t    state;
    seq_state_t    next_state;
    phrase_entry_t entry_q;
    phrase_entry_t next_entry;
    logic [3:0]    next_line;
    logic [3:0]    next_addr;
    logic          next_rd_en;
    logic          next_valid;
    logic          next_tick;
    logic          next_done;
    logic          carry;
    logic          nco_freeze;

    // Tempo only advances while a line is actually being played or fetched.
    assign nco_freeze = !(state == PLAY || state == WAIT);

    tempo_nco #(
        .ACC_WIDTH (ACC_WIDTH),
        .TEMPO_K   (TEMPO_K)
    ) u_tempo_nco (
        .clk              (clk),
        .reset_active_low (reset_active_low),
        .tempo            (tempo),
        .freeze           (nco_freeze),
        .clear            (stop),
        .carry            (carry)
    );

    assign current_entry = entry_q;

    // Next-state and next-output logic; stop overrides every state.
    always_comb begin
        next_state = state;
        next_line  = line_count;
        next_addr  = mem_addr;
        next_rd_en = 1'b0;
        next_tick  = 1'b0;
        next_entry = entry_q;
        next_valid = entry_valid;
        next_done  = phrase_done;

        if (stop) begin
            next_state = IDLE;
            next_line  = '0;
            next_addr  = '0;
            next_entry = '0;
            next_valid = 1'b0;
            next_done  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (play_enable) begin
                        next_rd_en = 1'b1;
                        next_addr  = line_count;
                        next_state = WAIT;
                    end
                end

                // The strobe is still high on the first WAIT cycle; the RAM
                // data is ready on the cycle after it drops.
                WAIT: begin
                    if (!mem_rd_en) begin
                        next_entry = phrase_entry_t'(mem_rd_data);
                        next_valid = play_enable;
                        next_state = play_enable ? PLAY : PAUSE;
                    end
                end

                // A line advance wins over a pause on the same edge; the
                // pause is then taken once the new line has been fetched.
                PLAY: begin
                    if (carry) begin
                        next_tick = 1'b1;
                        if (!is_last_line(line_count)) begin
                            next_line  = line_count + 4'd1;
                            next_addr  = line_count + 4'd1;
                            next_rd_en = 1'b1;
                            next_state = WAIT;
                        end else if (loop_enable) begin
                            next_line  = '0;
                            next_addr  = '0;
                            next_rd_en = 1'b1;
                            next_state = WAIT;
                        end else begin
                            next_valid = 1'b0;
                            next_done  = 1'b1;
                            next_state = DONE;
                        end
                    end else if (!play_enable) begin
                        next_valid = 1'b0;
                        next_state = PAUSE;
                    end
                end

                // Resume reuses the entry already held; no refetch.
                PAUSE: begin
                    if (play_enable) begin
                        next_valid = 1'b1;
                        next_state = PLAY;
                    end
                end

                DONE: begin
                    next_state = DONE;
                end

                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Register every output so downstream sees clean, glitch-free values.
    always_ff @(posedge clk or negedge reset_active_low) begin
        if (!reset_active_low) begin
            state       <= IDLE;
            line_count  <= '0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            line_tick   <= 1'b0;
            entry_q     <= '0;
            entry_valid <= 1'b0;
            phrase_done <= 1'b0;
        end else begin
            state       <= next_state;
            line_count  <= next_line;
            mem_addr    <= next_addr;
            mem_rd_en   <= next_rd_en;
            line_tick   <= next_tick;
            entry_q     <= next_entry;
            entry_valid <= next_valid;
            phrase_done <= next_done;
        end
    end

    // The shortest real line period dwarfs the two-cycle fetch, so a carry
    // arriving mid-fetch means the tempo constants are misconfigured.
    carry_in_wait: assert property (
        @(posedge clk) disable iff (!reset_active_low)
        !(state == WAIT && carry)
    );

endmodule

// File: tb/tb_phrase_sequencer.sv
// Self-checking bench for phrase_sequencer with a short line period
// (ACC_WIDTH=16, TEMPO_K=64, tempo=128: one line every 8 running cycles).
module tb_phrase_sequencer;

    logic        clk = 1'b0;
    logic        reset_active_low = 1'b1;
    logic [8:0]  tempo = '0;
    logic        play_enable = 1'b0;
    logic        loop_enable = 1'b0;
    logic        stop = 1'b0;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] current_entry;
    logic        entry_valid;
    logic [3:0]  line_count;
    logic        line_tick;
    logic        phrase_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic [15:0] sb[$];

    phrase_sequencer #(
        .ACC_WIDTH (16),
        .TEMPO_K   (64)
    ) dut (
        .clk              (clk),
        .reset_active_low (reset_active_low),
        .tempo            (tempo),
        .play_enable      (play_enable),
        .loop_enable      (loop_enable),
        .stop             (stop),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .current_entry    (current_entry),
        .entry_valid      (entry_valid),
        .line_count       (line_count),
        .line_tick        (line_tick),
        .phrase_done      (phrase_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running edge counter used to measure tick spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read phrase RAM: line n holds 16'h0100 + n.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'h0100 + 16'(mem_addr);
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pe, input logic lp, input logic st, input logic [8:0] tmp);
        play_enable = pe;
        loop_enable = lp;
        stop        = st;
        tempo       = tmp;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_entry"}, 32'(current_entry), 0);
        checkOutput({tag, "_valid"}, 32'(entry_valid), 0);
        checkOutput({tag, "_line"}, 32'(line_count), 0);
        checkOutput({tag, "_tick"}, 32'(line_tick), 0);
        checkOutput({tag, "_done"}, 32'(phrase_done), 0);
    endtask

    // Pop the next expected entry and compare it against what the DUT holds.
    task automatic checkEntry(input string tag);
        logic [15:0] exp_entry;
        checkOutput({tag, "_sb_avail"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            exp_entry = sb.pop_front();
            checkOutput({tag, "_entry"}, 32'(current_entry), 32'(exp_entry));
            checkOutput({tag, "_valid"}, 32'(entry_valid), 1);
        end
    endtask

    task automatic waitTick(input int budget, input string tag, output int when);
        bit seen;
        seen = 1'b0;
        when = cyc;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (line_tick) begin
                seen = 1'b1;
                when = cyc;
            end
        end
        checkOutput({tag, "_tick_seen"}, 32'(seen), 1);
    endtask

    task automatic startPlay(input logic lp, output int t0);
        applyStimulus(1'b1, lp, 1'b0, 9'd128);
        @(negedge clk);
        t0 = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic stopNow(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1, 9'd128);
        @(negedge clk);
        checkAllZero(tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd128);
    endtask

    initial begin
        int t;
        int t_last;
        int cnt;

        // Reset state.
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd128);
        #1 reset_active_low = 1'b0;
        #2 checkAllZero("reset");
        repeat (3) @(negedge clk);
        reset_active_low = 1'b1;
        @(negedge clk);

        // Basic playback with loop off, through to DONE.
        for (int l = 0; l < 16; l++) sb.push_back(16'h0100 + 16'(l));
        applyStimulus(1'b1, 1'b0, 1'b0, 9'd128);
        @(negedge clk);
        t_last = cyc;
        checkOutput("start_rd_en", 32'(mem_rd_en), 1);
        checkOutput("start_addr", 32'(mem_addr), 0);
        @(negedge clk);
        checkOutput("start_rd_drop", 32'(mem_rd_en), 0);
        checkOutput("start_valid_pre", 32'(entry_valid), 0);
        @(negedge clk);
        checkEntry("start");
        for (int l = 1; l < 16; l++) begin
            waitTick(20, "basic", t);
            checkOutput("basic_period", 32'(t - t_last), 8);
            t_last = t;
            checkOutput("basic_line", 32'(line_count), 32'(l));
            checkOutput("basic_rd_en", 32'(mem_rd_en), 1);
            checkOutput("basic_addr", 32'(mem_addr), 32'(l));
            checkOutput("basic_hold_valid", 32'(entry_valid), 1);
            repeat (2) @(negedge clk);
            checkEntry("basic");
        end
        waitTick(20, "last", t);
        checkOutput("last_period", 32'(t - t_last), 8);
        checkOutput("last_done", 32'(phrase_done), 1);
        checkOutput("last_valid", 32'(entry_valid), 0);
        checkOutput("last_line", 32'(line_count), 15);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_rd_en) cnt++;
        end
        checkOutput("done_no_reads", 32'(cnt), 0);
        checkOutput("done_hold", 32'(phrase_done), 1);
        checkOutput("done_line", 32'(line_count), 15);
        stopNow("stop_done");

        // Tempo zero: no line advances.
        sb.push_back(16'h0100);
        startPlay(1'b1, t_last);
        checkEntry("t0_start");
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (line_tick) cnt++;
        end
        checkOutput("tempo0_ticks", 32'(cnt), 0);
        checkOutput("tempo0_line", 32'(line_count), 0);
        stopNow("stop_t0");

        // Stop while a fetch is in flight: data must be dropped.
        sb.push_back(16'h0100);
        startPlay(1'b1, t_last);
        checkEntry("sw_start");
        waitTick(20, "sw", t);
        checkOutput("sw_rd_en", 32'(mem_rd_en), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 9'd128);
        @(negedge clk);
        checkAllZero("stop_wait");
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd128);
        repeat (5) @(negedge clk);
        checkOutput("sw_dropped_entry", 32'(current_entry), 0);
        checkOutput("sw_dropped_valid", 32'(entry_valid), 0);

        // Loop: three full laps.
        for (int n = 0; n <= 48; n++) sb.push_back(16'h0100 + 16'(n % 16));
        startPlay(1'b1, t_last);
        checkEntry("loop_start");
        for (int n = 1; n <= 48; n++) begin
            waitTick(20, "loop", t);
            checkOutput("loop_period", 32'(t - t_last), 8);
            t_last = t;
            checkOutput("loop_line", 32'(line_count), 32'(n % 16));
            checkOutput("loop_done", 32'(phrase_done), 0);
            repeat (2) @(negedge clk);
            checkEntry("loop");
        end
        stopNow("stop_loop");

        // Pause for 20 cycles on line 5.
        for (int n = 0; n <= 6; n++) sb.push_back(16'h0100 + 16'(n));
        startPlay(1'b1, t_last);
        checkEntry("pz_start");
        for (int n = 1; n <= 5; n++) begin
            waitTick(20, "pz", t);
            t_last = t;
            repeat (2) @(negedge clk);
            checkEntry("pz");
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 9'd128);
        @(negedge clk);
        checkOutput("pause_valid", 32'(entry_valid), 0);
        cnt = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (line_tick) cnt++;
        end
        checkOutput("pause_ticks", 32'(cnt), 0);
        checkOutput("pause_line", 32'(line_count), 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 9'd128);
        @(negedge clk);
        checkOutput("resume_valid", 32'(entry_valid), 1);
        checkOutput("resume_entry", 32'(current_entry), 32'h0105);
        waitTick(40, "resume", t);
        checkOutput("resume_period", 32'(t - t_last), 28);
        checkOutput("resume_line", 32'(line_count), 6);
        repeat (2) @(negedge clk);
        checkEntry("resume");

        // Asynchronous reset mid-line, checked before any clock edge.
        repeat (3) @(negedge clk);
        #2 reset_active_low = 1'b0;
        #1 checkAllZero("async_reset");
        @(negedge clk);
        reset_active_low = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 9'd128);
        @(negedge clk);

        checkOutput("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
